// File: rtl/alu_seq.sv
// Registered add/sub/logic unit with a multi-cycle shift-add unsigned multiplier.
// Single-cycle ops complete on the start edge; MUL takes WIDTH steps behind busy.
`timescale 1ns/1ps
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [0:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] prod_next;

    // SUB reuses the adder as a + ~b + 1; reserved ops fall through to all-zero.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        b_eff   = (op == OP_SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // Step cnt adds the multiplicand shifted by cnt when the current multiplier LSB is set.
    always_comb begin
        addend    = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        prod_next = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            z_lo   <= '0;
            z_hi   <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_MUL;
                    end else begin
                        z_lo  <= alu_res;
                        z_hi  <= '0;
                        carry <= alu_c;
                        ovf   <= alu_v;
                        zero  <= (alu_res == '0);
                        neg   <= alu_res[WIDTH-1];
                        done  <= 1'b1;
                    end
                end
            end else begin
                acc    <= prod_next;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (cnt == LAST_STEP) begin
                    z_hi  <= prod_next[2*WIDTH-1:WIDTH];
                    z_lo  <= prod_next[WIDTH-1:0];
                    carry <= |prod_next[2*WIDTH-1:WIDTH];
                    ovf   <= |prod_next[2*WIDTH-1:WIDTH];
                    zero  <= (prod_next == '0);
                    neg   <= prod_next[2*WIDTH-1];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule
